radix4_divider: RTL and testbench

Sequential radix-4 restoring divider: divides a 2N-bit unsigned dividend by an N-bit unsigned divisor, producing an N-bit quotient and N-bit remainder. It retires two quotient bits per cycle. It is the inverse of the datapath's combinational radix-4 Booth multipliers: it accepts a full 2N-bit product-width operand and recovers one factor. A start/busy/done handshake lets a controller issue one division at a time.

---
 rtl/radix4_divider.sv | 185 ++++++++++++++++++
 tb/tb_radix4_divider.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/radix4_divider.sv
// rtl/radix4_divider.sv - sequential radix-4 restoring divider, 2N-bit by N-bit unsigned
//
// Divides a 2N-bit unsigned dividend by an N-bit unsigned divisor and retires
// two quotient bits per clock. One division is in flight at a time, under a
// start/busy/done handshake. Divide-by-zero and quotient overflow are detected
// when the operands are accepted, and they finish in a single cycle.
//
// Ports:
//   clk    in   1    rising-edge clock
//   rst_n  in   1    asynchronous active-low reset
//   start  in   1    division request, sampled only when not busy
//   p      in   2N   unsigned dividend, captured with an accepted start
//   d      in   N    unsigned divisor, captured with an accepted start
//   busy   out  1    a division is iterating
//   done   out  1    one-cycle pulse; q/r/ovf/dz are valid and then held
//   q      out  N    quotient
//   r      out  N    remainder
//   ovf    out  1    the quotient does not fit in N bits
//   dz     out  1    divide by zero

`timescale 1ns/1ps

module radix4_divider #(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*N-1:0] p,
    input  logic [N-1:0]   d,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   q,
    output logic [N-1:0]   r,
    output logic           ovf,
    output logic           dz
);

    localparam int K  = N / 2;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N+1:0]   rem_q, rem_d;      // partial remainder; always < divisor
    logic [N-1:0]   plo_q, plo_d;      // low dividend half, consumed MSB pair first
    logic [N-1:0]   dvs_q, dvs_d;      // captured divisor
    logic [N-1:0]   quo_q, quo_d;      // quotient being assembled
    logic [CW-1:0]  cnt_q, cnt_d;      // iteration index
    logic [N-1:0]   q_q, q_d;
    logic [N-1:0]   r_q, r_d;
    logic           ovf_q, ovf_d;
    logic           dz_q, dz_d;

    // One radix-4 step: bring in the next two dividend bits and subtract the
    // largest multiple of the divisor (0..3) that still fits.
    logic [N+1:0]   t_w;
    logic [N+1:0]   d1_w, d2_w, d3_w;
    logic [N+1:0]   rem_next_w;
    logic [1:0]     m_w;
    logic [N-1:0]   quo_next_w;

    always_comb begin
        // rem_q < divisor, so its top two bits are zero and this shift loses nothing.
        t_w  = {rem_q[N-1:0], plo_q[N-1:N-2]};
        d1_w = {2'b00, dvs_q};
        d2_w = {1'b0, dvs_q, 1'b0};
        d3_w = d1_w + d2_w;
        if (t_w >= d3_w) begin
            m_w        = 2'd3;
            rem_next_w = t_w - d3_w;
        end else if (t_w >= d2_w) begin
            m_w        = 2'd2;
            rem_next_w = t_w - d2_w;
        end else if (t_w >= d1_w) begin
            m_w        = 2'd1;
            rem_next_w = t_w - d1_w;
        end else begin
            m_w        = 2'd0;
            rem_next_w = t_w;
        end
        quo_next_w = {quo_q[N-3:0], m_w};
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        plo_d   = plo_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    plo_d = p[N-1:0];
                    dvs_d = d;
                    rem_d = {2'b00, p[2*N-1:N]};
                    quo_d = '0;
                    cnt_d = '0;
                    if (d == '0) begin
                        state_d = S_DONE;
                        q_d     = '1;
                        r_d     = p[N-1:0];
                        ovf_d   = 1'b0;
                        dz_d    = 1'b1;
                    end else if (p[2*N-1:N] >= d) begin
                        // The high half alone already needs a quotient >= 2^N.
                        state_d = S_DONE;
                        q_d     = '1;
                        r_d     = '0;
                        ovf_d   = 1'b1;
                        dz_d    = 1'b0;
                    end else begin
                        state_d = S_RUN;
                    end
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end

            S_RUN: begin
                rem_d = rem_next_w;
                quo_d = quo_next_w;
                plo_d = {plo_q[N-3:0], 2'b00};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(K - 1)) begin
                    state_d = S_DONE;
                    q_d     = quo_next_w;
                    r_d     = rem_next_w[N-1:0];
                    ovf_d   = 1'b0;
                    dz_d    = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            plo_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            plo_q   <= plo_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
        end
    end

    // Status is decoded from the state register only, so there is no path from
    // the inputs to the outputs.
    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign q    = q_q;
    assign r    = r_q;
    assign ovf  = ovf_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_radix4_divider.sv
// tb/tb_radix4_divider.sv - self-checking bench for radix4_divider

`timescale 1ns/1ps

module tb_radix4_divider;

    localparam int N = 16;
    localparam int K = N / 2;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [2*N-1:0] p;
    logic [N-1:0]   d;
    logic           busy;
    logic           done;
    logic [N-1:0]   q;
    logic [N-1:0]   r;
    logic           ovf;
    logic           dz;

    int checks = 0;
    int errors = 0;

    radix4_divider #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .p     (p),
        .d     (d),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .r     (r),
        .ovf   (ovf),
        .dz    (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference division from the arithmetic definition.
    function automatic void model(input logic [31:0] pv, input logic [15:0] dv,
                                  output logic [15:0] eq, output logic [15:0] er,
                                  output logic eovf, output logic edz);
        if (dv == 16'd0) begin
            eq = 16'hFFFF; er = pv[15:0]; eovf = 1'b0; edz = 1'b1;
        end else if ((pv / {16'd0, dv}) > 32'h0000_FFFF) begin
            eq = 16'hFFFF; er = 16'd0; eovf = 1'b1; edz = 1'b0;
        end else begin
            eq = 16'(pv / {16'd0, dv});
            er = 16'(pv % {16'd0, dv});
            eovf = 1'b0; edz = 1'b0;
        end
    endfunction

    // Issue one division from an idle bus and check latency, busy width and results.
    task automatic run_div(input string tag, input logic [31:0] pv, input logic [15:0] dv,
                           input logic [15:0] eq, input logic [15:0] er,
                           input logic eovf, input logic edz);
        int lat;
        int bcnt;
        bit fast;
        fast = eovf || edz;
        @(negedge clk);
        start = 1'b1; p = pv; d = dv;
        @(negedge clk);
        start = 1'b0;
        lat = 1; bcnt = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, lat, fast ? 1 : K + 1);
        check({tag, ".busy_cycles"}, bcnt, fast ? 0 : K);
        check({tag, ".busy_at_done"}, {31'd0, busy}, 32'd0);
        check({tag, ".q"}, {16'd0, q}, {16'd0, eq});
        check({tag, ".r"}, {16'd0, r}, {16'd0, er});
        check({tag, ".ovf"}, {31'd0, ovf}, {31'd0, eovf});
        check({tag, ".dz"}, {31'd0, dz}, {31'd0, edz});
        @(negedge clk);
        check({tag, ".done_width"}, {31'd0, done}, 32'd0);
        check({tag, ".q_held"}, {16'd0, q}, {16'd0, eq});
    endtask

    initial begin
        logic [15:0] eq, er;
        logic        eovf, edz;
        logic [15:0] a, b, c;
        logic [31:0] pv;
        int          kind;
        int          w;
        bit          exp_done;

        rst_n = 1'b0; start = 1'b0; p = '0; d = '0;
        repeat (2) @(negedge clk);
        check("reset.busy", {31'd0, busy}, 32'd0);
        check("reset.done", {31'd0, done}, 32'd0);
        check("reset.q", {16'd0, q}, 32'd0);
        check("reset.r", {16'd0, r}, 32'd0);
        check("reset.ovf_dz", {30'd0, ovf, dz}, 32'd0);
        rst_n = 1'b1;

        // Directed cases
        run_div("basic", 32'd1000, 16'd7, 16'd142, 16'd6, 1'b0, 1'b0);
        run_div("max_exact", 32'hFFFE0001, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
        run_div("max_rem", 32'hFFFEFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 1'b0);
        run_div("div_zero", 32'h0001_2345, 16'd0, 16'hFFFF, 16'h2345, 1'b0, 1'b1);
        run_div("overflow", 32'h0007_0000, 16'd7, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
        run_div("just_fits", 32'h0006_FFFF, 16'd7, 16'hFFFF, 16'h0006, 1'b0, 1'b0);

        // start held for 20 edges: divisions chain through the DONE cycles,
        // and operand changes during RUN are ignored until the next accept.
        @(negedge clk);
        start = 1'b1; p = 32'd1000; d = 16'd7;
        for (int i = 1; i <= 27; i++) begin
            @(negedge clk);
            if (i == 1) begin p = 32'h0012_3456; d = 16'h0100; end
            if (i == 20) start = 1'b0;
            exp_done = (i % 9 == 0);
            check($sformatf("hold.done[%0d]", i), {31'd0, done}, {31'd0, exp_done});
            check($sformatf("hold.busy[%0d]", i), {31'd0, busy}, {31'd0, !exp_done});
            if (i == 9) begin
                check("hold.q1", {16'd0, q}, 32'd142);
                check("hold.r1", {16'd0, r}, 32'd6);
            end
            if (i == 10) check("hold.q_during_run", {16'd0, q}, 32'd142);
            if (i == 18 || i == 27) begin
                check($sformatf("hold.q[%0d]", i), {16'd0, q}, 32'h1234);
                check($sformatf("hold.r[%0d]", i), {16'd0, r}, 32'h0056);
            end
        end
        @(negedge clk);
        check("hold.idle_after", {30'd0, busy, done}, 32'd0);

        // A divide-by-zero accepted in the DONE cycle keeps done high one more cycle.
        @(negedge clk);
        start = 1'b1; p = 32'd1000; d = 16'd7;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (done !== 1'b1 && w < 40) begin @(negedge clk); w++; end
        check("b2b.first_done", {31'd0, done}, 32'd1);
        check("b2b.first_q", {16'd0, q}, 32'd142);
        start = 1'b1; p = 32'h0001_2345; d = 16'd0;
        @(negedge clk);
        start = 1'b0;
        check("b2b.done_again", {31'd0, done}, 32'd1);
        check("b2b.dz", {31'd0, dz}, 32'd1);
        check("b2b.r", {16'd0, r}, 32'h2345);
        check("b2b.busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("b2b.done_end", {31'd0, done}, 32'd0);

        // Reset in the middle of an iteration discards the division.
        @(negedge clk);
        start = 1'b1; p = 32'h0012_3456; d = 16'h0100;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst.busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst.busy", {31'd0, busy}, 32'd0);
        check("midrst.done", {31'd0, done}, 32'd0);
        check("midrst.q", {16'd0, q}, 32'd0);
        check("midrst.r", {16'd0, r}, 32'd0);
        check("midrst.ovf_dz", {30'd0, ovf, dz}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_div("after_rst", 32'd1000, 16'd7, 16'd142, 16'd6, 1'b0, 1'b0);

        // Randomised vectors: round trips p = a*b + c plus dz and ovf cases.
        for (int n = 0; n < 4000; n++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                pv = $urandom;
                model(pv, 16'd0, eq, er, eovf, edz);
                run_div("rand_dz", pv, 16'd0, eq, er, eovf, edz);
            end else if (kind == 1) begin
                b  = 16'($urandom_range(1, 65535));
                a  = 16'($urandom_range(int'(b), 65535));
                pv = {a, 16'($urandom)};
                model(pv, b, eq, er, eovf, edz);
                run_div("rand_ovf", pv, b, eq, er, eovf, edz);
            end else begin
                a  = 16'($urandom);
                b  = 16'($urandom_range(1, 65535));
                c  = 16'($urandom_range(0, int'(b) - 1));
                pv = {16'd0, a} * {16'd0, b} + {16'd0, c};
                run_div("rand_rt", pv, b, a, c, 1'b0, 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
